// File: rtl/busy_table_ckpt.sv
// busy_table_ckpt: physical-register busy-bit table with a circular FIFO of
// busy-list checkpoints. A branch recall restores the busy list from an
// internal snapshot, so no external recalled list is needed.
// Optional build macro: PREG_ZERO_HARDWIRE_EN (register 0 is never busy).

`ifndef NUM_INSTRS_COMPLETED
`define NUM_INSTRS_COMPLETED 2
`endif

module busy_table_ckpt #(
   parameter int unsigned NUM_PREGS = 64,
   parameter int unsigned PREG_W    = 6,
   parameter int unsigned NUM_ALLOC = 2,
   parameter int unsigned NUM_DONE  = `NUM_INSTRS_COMPLETED,
   parameter int unsigned NUM_CKPT  = 4,
   parameter int unsigned CKPT_W    = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_ALLOC-1:0]                busify,
   input  logic [NUM_ALLOC-1:0][PREG_W-1:0]    busy_addr,
   input  logic                                ext_stall,
   input  logic [NUM_DONE-1:0]                 done,
   input  logic [NUM_DONE-1:0][PREG_W-1:0]     done_addr,
   input  logic                                ckpt_alloc,
   output logic [CKPT_W-1:0]                   ckpt_id,
   output logic                                ckpt_full,
   input  logic                                ckpt_release,
   input  logic                                recall,
   input  logic [CKPT_W-1:0]                   recall_id,
   output logic [NUM_PREGS-1:0]                expected_list,
   output logic [NUM_PREGS-1:0]                busy_list
);

   localparam int unsigned CNT_W = CKPT_W + 1;

   logic [NUM_PREGS-1:0]                busy_q;
   logic [NUM_CKPT-1:0][NUM_PREGS-1:0]  snap_q, snap_d;
   logic [CKPT_W-1:0]                   head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]                    count_q, count_d;

   logic [NUM_PREGS-1:0]                done_mask;
   logic [NUM_PREGS-1:0]                busify_mask;
   logic [NUM_PREGS-1:0]                exp_list;
   logic                                alloc_ok;
   logic                                release_ok;
   logic [CKPT_W-1:0]                   head_pop;

   assign ckpt_full     = (count_q == CNT_W'(NUM_CKPT));
   assign ckpt_id       = tail_q;
   assign busy_list     = busy_q;
   assign expected_list = exp_list;

   assign alloc_ok   = ckpt_alloc && !ext_stall && !recall && !ckpt_full;
   assign release_ok = ckpt_release && (count_q != '0);
   assign head_pop   = release_ok ? head_q + CKPT_W'(1) : head_q;

   // Decode writeback clears and busify requests into per-register masks
   always_comb begin
      done_mask   = '0;
      busify_mask = '0;
      for (int unsigned j = 0; j < NUM_DONE; j++) begin
         if (done[j]) done_mask[done_addr[j]] = 1'b1;
      end
      for (int unsigned i = 0; i < NUM_ALLOC; i++) begin
`ifdef PREG_ZERO_HARDWIRE_EN
         if (busify[i] && !ext_stall && (busy_addr[i] != '0)) busify_mask[busy_addr[i]] = 1'b1;
`else
         if (busify[i] && !ext_stall) busify_mask[busy_addr[i]] = 1'b1;
`endif
      end
   end

   // Next busy list: recall restores a snapshot, otherwise busify beats done
   always_comb begin
      if (recall) begin
         exp_list = snap_q[recall_id] & ~done_mask;
      end else begin
         exp_list = busify_mask | (busy_q & ~done_mask);
      end
`ifdef PREG_ZERO_HARDWIRE_EN
      exp_list[0] = 1'b0;
`endif
   end

   // Checkpoint FIFO next state: done clears scrub every slot, alloc writes tail
   always_comb begin
      head_d  = head_pop;
      tail_d  = tail_q;
      count_d = count_q;
      for (int unsigned k = 0; k < NUM_CKPT; k++) begin
         snap_d[k] = snap_q[k] & ~done_mask;
      end
      if (recall) begin
         // Release pops first, so the surviving count is measured from the new head
         tail_d  = recall_id;
         count_d = {1'b0, CKPT_W'(recall_id - head_pop)};
      end else begin
         if (alloc_ok) begin
            snap_d[tail_q] = exp_list;
            tail_d         = tail_q + CKPT_W'(1);
         end
         count_d = count_q + CNT_W'(alloc_ok) - CNT_W'(release_ok);
      end
   end

   // State registers with synchronous reset taking priority over recall
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q  <= '0;
         snap_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= exp_list;
         snap_q  <= snap_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

`ifndef SYNTHESIS
   logic [CKPT_W-1:0] recall_off;
   logic [CNT_W-1:0]  live_after_pop;
   assign recall_off     = recall_id - head_pop;
   assign live_after_pop = count_q - CNT_W'(release_ok);

   // Protocol checks: alloc while full, and recall of a slot that is not live
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(ckpt_alloc && !ext_stall && !recall && ckpt_full))
            else $warning("busy_table_ckpt: ckpt_alloc while checkpoint FIFO is full, ignored");
         assert (!recall || (CNT_W'(recall_off) < live_after_pop))
            else $error("busy_table_ckpt: recall_id %0d is not a live checkpoint", recall_id);
      end
   end
`endif

endmodule

// File: tb/tb_busy_table_ckpt.sv
// Directed testbench for busy_table_ckpt with hand-computed expected values.

`ifndef NUM_INSTRS_COMPLETED
`define NUM_INSTRS_COMPLETED 2
`endif

module tb_busy_table_ckpt;

   localparam int ND = `NUM_INSTRS_COMPLETED;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        busify;
   logic [1:0][5:0]   busy_addr;
   logic              ext_stall;
   logic [ND-1:0]     done;
   logic [ND-1:0][5:0] done_addr;
   logic              ckpt_alloc;
   logic [1:0]        ckpt_id;
   logic              ckpt_full;
   logic              ckpt_release;
   logic              recall;
   logic [1:0]        recall_id;
   logic [63:0]       expected_list;
   logic [63:0]       busy_list;

   int n_checks = 0;
   int n_errors = 0;

   busy_table_ckpt #(
      .NUM_PREGS (64),
      .PREG_W    (6),
      .NUM_ALLOC (2),
      .NUM_DONE  (ND),
      .NUM_CKPT  (4),
      .CKPT_W    (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .busify        (busify),
      .busy_addr     (busy_addr),
      .ext_stall     (ext_stall),
      .done          (done),
      .done_addr     (done_addr),
      .ckpt_alloc    (ckpt_alloc),
      .ckpt_id       (ckpt_id),
      .ckpt_full     (ckpt_full),
      .ckpt_release  (ckpt_release),
      .recall        (recall),
      .recall_id     (recall_id),
      .expected_list (expected_list),
      .busy_list     (busy_list)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] b(input int a);
      return 64'(1) << a;
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic idle();
      busify       = '0;
      busy_addr    = '0;
      ext_stall    = 1'b0;
      done         = '0;
      done_addr    = '0;
      ckpt_alloc   = 1'b0;
      ckpt_release = 1'b0;
      recall       = 1'b0;
      recall_id    = '0;
   endtask

   // Advance one clock; inputs are changed 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bz(input int port, input int addr);
      busify[port]    = 1'b1;
      busy_addr[port] = 6'(addr);
   endtask

   task automatic dn(input int addr);
      done[0]      = 1'b1;
      done_addr[0] = 6'(addr);
   endtask

   logic [63:0] z0;

   initial begin
      idle();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_busy", busy_list, 64'd0);
      chk("rst_exp", expected_list, 64'd0);
      chk("rst_id", 64'(ckpt_id), 64'd0);
      chk("rst_full", 64'(ckpt_full), 64'd0);

      // 1: busify 5 and 9
      bz(0, 5); bz(1, 9);
      #1 chk("t1_bypass", expected_list, b(5) | b(9));
      tick(); idle();
      chk("t1_busy", busy_list, b(5) | b(9));
      chk("t1_id", 64'(ckpt_id), 64'd0);
      chk("t1_full", 64'(ckpt_full), 64'd0);

      // 2: busify beats done; done alone clears; stall blocks busify
      bz(0, 7); dn(7);
      #1 chk("t2_bypass", expected_list, b(5) | b(7) | b(9));
      tick(); idle();
      chk("t2_busy_win", busy_list, b(5) | b(7) | b(9));
      dn(7);
      tick(); idle();
      chk("t2_done", busy_list, b(5) | b(9));
      ext_stall = 1'b1; bz(0, 7);
      #1 chk("t2_stall_exp", expected_list, b(5) | b(9));
      tick(); idle();
      chk("t2_stall_busy", busy_list, b(5) | b(9));

      // 3: snapshot includes same-cycle busify; done scrubs the snapshot
      bz(0, 12); ckpt_alloc = 1'b1;
      #1 chk("t3_id0", 64'(ckpt_id), 64'd0);
      tick(); idle();
      chk("t3_busy12", busy_list, b(5) | b(9) | b(12));
      chk("t3_id1", 64'(ckpt_id), 64'd1);
      bz(0, 13);
      tick(); idle();
      dn(12);
      tick(); idle();
      chk("t3_pre", busy_list, b(5) | b(9) | b(13));
      recall = 1'b1; recall_id = 2'd0;
      #1 chk("t3_rec_exp", expected_list, b(5) | b(9));
      tick(); idle();
      chk("t3_rec_busy", busy_list, b(5) | b(9));
      chk("t3_rec_id", 64'(ckpt_id), 64'd0);
      chk("t3_rec_full", 64'(ckpt_full), 64'd0);

      // 4: fill, ignored alloc while full, release, wrap
      for (int i = 0; i < 4; i++) begin
         ckpt_alloc = 1'b1;
         #1;
         chk("t4_fill_id", 64'(ckpt_id), 64'(i));
         chk("t4_fill_nf", 64'(ckpt_full), 64'd0);
         tick(); idle();
      end
      chk("t4_full", 64'(ckpt_full), 64'd1);
      chk("t4_full_id", 64'(ckpt_id), 64'd0);
      ckpt_alloc = 1'b1;
      tick(); idle();
      chk("t4_ovf_full", 64'(ckpt_full), 64'd1);
      chk("t4_ovf_id", 64'(ckpt_id), 64'd0);
      chk("t4_ovf_busy", busy_list, b(5) | b(9));
      ckpt_release = 1'b1;
      tick(); idle();
      chk("t4_rel_full", 64'(ckpt_full), 64'd0);
      ckpt_alloc = 1'b1;
      #1 chk("t4_wrap_id", 64'(ckpt_id), 64'd0);
      tick(); idle();
      chk("t4_wrap_full", 64'(ckpt_full), 64'd1);
      chk("t4_wrap_id1", 64'(ckpt_id), 64'd1);

      // 5: head=1, ids 1..3, recall id 2 with a same-cycle done
      reset = 1'b1;
      tick(); reset = 1'b0; idle();
      ckpt_alloc = 1'b1;
      tick(); idle();
      ckpt_release = 1'b1;
      tick(); idle();
      for (int i = 1; i <= 3; i++) begin
         bz(0, 19 + i); ckpt_alloc = 1'b1;
         #1 chk("t5_alloc_id", 64'(ckpt_id), 64'(i));
         tick(); idle();
      end
      chk("t5_pre", busy_list, b(20) | b(21) | b(22));
      recall = 1'b1; recall_id = 2'd2; dn(20);
      #1 chk("t5_rec_exp", expected_list, b(21));
      tick(); idle();
      chk("t5_rec_busy", busy_list, b(21));
      chk("t5_rec_id", 64'(ckpt_id), 64'd2);
      chk("t5_rec_full", 64'(ckpt_full), 64'd0);
      // count is 1 after the recall, so three more allocs fill the FIFO
      for (int i = 0; i < 3; i++) begin
         ckpt_alloc = 1'b1;
         #1 chk("t5_next_id", 64'((2 + i) % 4), 64'(ckpt_id));
         tick(); idle();
         chk("t5_next_full", 64'(ckpt_full), (i == 2) ? 64'd1 : 64'd0);
      end

      // 6: reset during recall wins
      reset = 1'b1; recall = 1'b1; recall_id = 2'd2; bz(0, 40);
      tick(); reset = 1'b0; idle();
      #1;
      chk("t6_busy", busy_list, 64'd0);
      chk("t6_exp", expected_list, 64'd0);
      chk("t6_id", 64'(ckpt_id), 64'd0);
      chk("t6_full", 64'(ckpt_full), 64'd0);
      // release on empty is ignored: still exactly four allocs to fill
      ckpt_release = 1'b1;
      tick(); idle();
      chk("t6_rel_empty_id", 64'(ckpt_id), 64'd0);
      for (int i = 0; i < 4; i++) begin
         ckpt_alloc = 1'b1;
         tick(); idle();
         chk("t6_fill_full", 64'(ckpt_full), (i == 3) ? 64'd1 : 64'd0);
      end
      // busify register 0 on both ports (duplicate address)
`ifdef PREG_ZERO_HARDWIRE_EN
      z0 = 64'd0;
`else
      z0 = b(0);
`endif
      bz(0, 0); bz(1, 0);
      #1 chk("t6_zero_exp", expected_list, z0);
      tick(); idle();
      chk("t6_zero_busy", busy_list, z0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
